lc3b_mem_arbiter: RTL and testbench
===================================

Name: lc3b_mem_arbiter

Overview:
- Shares the single physical-memory port between the LC-3b instruction-fetch cache (I side, read-only) and the data cache (D side, read/write).
- Sits between both caches and the pmem interface.
- Grants one whole line transaction at a time and forwards the pmem response to the granted requester.
- D side has priority; a starvation counter guarantees I-fetch progress.

Parameters:
- LINE_W, 128, cache line width in bits; must be a power of two, at least 16.
- STARVE_LIMIT, 4, consecutive D grants allowed while an I request waits before I is forced; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_read  in  1  I-side line read request; level, held until i_resp.
- i_address  in  16  I-side byte address (lc3b_word).
- i_rdata  out  LINE_W  read line returned to the I side.
- i_resp  out  1  one-cycle completion pulse to the I side.
- d_read  in  1  D-side line read request; level, held until d_resp.
- d_write  in  1  D-side line write request; level, held until d_resp.
- d_address  in  16  D-side byte address.
- d_wdata  in  LINE_W  D-side write line.
- d_rdata  out  LINE_W  read line returned to the D side.
- d_resp  out  1  one-cycle completion pulse to the D side.
- pmem_read  out  1  read command to physical memory.
- pmem_write  out  1  write command to physical memory.
- pmem_address  out  16  line-aligned address to physical memory.
- pmem_wdata  out  LINE_W  write line to physical memory.
- pmem_rdata  in  LINE_W  read line from physical memory.
- pmem_resp  in  1  physical memory completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Grant owner is encoded by state. Streak counter is 4 bits, saturating at 15.
- Reset (async): state goes to IDLE and streak to 0. All outputs are 0: pmem_read, pmem_write, i_resp, d_resp, busy, pmem_address, pmem_wdata.
- i_rdata and d_rdata:
  - always equal pmem_rdata (passthrough);
  - meaningful only while the matching resp is high.
- IDLE, grant decision:
  - d_req = d_read | d_write.
  - If d_req and i_read and streak ≥ STARVE_LIMIT: go to SERVE_I.
  - Else if d_req: go to SERVE_D.
  - Else if i_read: go to SERVE_I.
  - Else stay in IDLE.
  - pmem commands are 0 while in IDLE.
- Streak update, on the IDLE→SERVE_D edge:
  - increment if i_read was high that cycle;
  - otherwise clear to 0.
  - Any IDLE→SERVE_I edge clears streak to 0.
- SERVE_I:
  - pmem_read = 1, pmem_write = 0, pmem_address = i_address with low log2(LINE_W/8) bits zeroed.
  - pmem_wdata = 0.
- SERVE_D:
  - pmem_write = d_write.
  - pmem_read = d_read & ~d_write, so write wins if both are asserted.
  - pmem_address = aligned d_address; pmem_wdata = d_wdata.
- Completion:
  - In SERVE_x, when pmem_resp = 1, drive x_resp = 1 combinationally in the same cycle, then return to IDLE.
  - The other side's resp stays 0.
- Latency:
  - A request seen in IDLE at cycle 0 puts the pmem command on the bus at cycle 1.
  - x_resp coincides with pmem_resp.
  - At least one IDLE cycle separates consecutive transactions, so a still-high request after its resp is not regranted until the requester drops it or the next IDLE evaluation.
- Requesters must lower their request in the cycle after resp. A request still high in IDLE is treated as a new request.
- Protocol violations:
  - If a requester drops its request mid-transaction, the arbiter stays in SERVE_x until pmem_resp. It does not abort, and resp is still pulsed.
  - pmem_resp while in IDLE is ignored; no resp is generated.
- Reset mid-transaction: immediate return to IDLE with outputs 0. A later stale pmem_resp is ignored.
- busy = (state != IDLE).

Test Plan:
- I-only read: i_read=1, i_address=0x1236, pmem_resp after 3 cycles with pmem_rdata=0xA5..A5 → pmem_read=1 at cycle 1, pmem_address=0x1230, i_resp pulse for 1 cycle with i_rdata=0xA5..A5, d_resp=0.
- D write: d_write=1, d_address=0x4008, d_wdata=0x0123..CDEF → pmem_write=1, pmem_read=0, pmem_address=0x4000, pmem_wdata matches, d_resp on pmem_resp.
- Simultaneous requests in IDLE: i_read=1, d_read=1 → D served first; after d_resp and one IDLE cycle, I served.
- Starvation with STARVE_LIMIT=4: i_read held, D requests back-to-back → exactly 4 D grants, then I granted; streak returns to 0.
- Reset while in SERVE_D (pmem_write=1): assert rst → same-cycle pmem_write=0, busy=0; pmem_resp pulse 2 cycles later → no d_resp and no i_resp.
- d_read and d_write both high → pmem_write=1, pmem_read=0; single d_resp.

Source files
------------

// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_arbiter
// Purpose  : Shares one physical-memory port between the LC-3b I-cache
//            (read-only) and D-cache (read/write), one line at a time.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_arbiter #(
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [15:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [15:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              busy
);

    localparam int          c_OFFSET_W   = $clog2(LINE_W / 8);
    localparam logic [15:0] c_ALIGN_MASK = 16'hFFFF << c_OFFSET_W;
    localparam logic [3:0]  c_STARVE     = 4'(STARVE_LIMIT);
    localparam logic [3:0]  c_STREAK_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_streak;

    logic       w_d_req;
    logic       w_force_i;
    logic [3:0] w_streak_inc;

    assign w_d_req      = d_read | d_write;
    assign w_force_i    = w_d_req & i_read & (r_streak >= c_STARVE);
    assign w_streak_inc = (r_streak == c_STREAK_MAX) ? r_streak : r_streak + 4'd1;

    // r_streak counts D grants taken while an I fetch was already waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_streak <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_force_i) begin
                        r_state  <= ST_SERVE_I;
                        r_streak <= 4'd0;
                    end else if (w_d_req) begin
                        r_state  <= ST_SERVE_D;
                        r_streak <= i_read ? w_streak_inc : 4'd0;
                    end else if (i_read) begin
                        r_state  <= ST_SERVE_I;
                        r_streak <= 4'd0;
                    end
                end
                ST_SERVE_I: begin
                    if (pmem_resp) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Commands decode straight from state so an async reset clears them at once.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            ST_SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address & c_ALIGN_MASK;
                i_resp       = pmem_resp;
            end
            ST_SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address & c_ALIGN_MASK;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_mem_arbiter
// Purpose  : Directed + randomized scoreboard bench for lc3b_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_arbiter;

    localparam int LW  = 128;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [15:0]   i_address = 16'h0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [15:0]   d_address = 16'h0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          busy;

    logic          auto_pmem = 1'b0;
    logic          mon_en    = 1'b0;
    logic          m_resp    = 1'b0;
    logic [LW-1:0] m_rdata   = '0;
    logic          a_resp    = 1'b0;
    logic [LW-1:0] a_rdata   = '0;

    assign pmem_resp  = auto_pmem ? a_resp  : m_resp;
    assign pmem_rdata = auto_pmem ? a_rdata : m_rdata;

    int total = 0;
    int bad   = 0;

    logic [LW:0]   dq[$];
    logic [LW-1:0] iq[$];
    logic [LW-1:0] ref_mem[logic [15:0]];
    logic [LW-1:0] pm_mem[logic [15:0]];

    lc3b_mem_arbiter #(.LINE_W(LW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default line contents of untouched memory, keyed by line address.
    function automatic logic [LW-1:0] hsh(input logic [15:0] a);
        return {a, ~a, a ^ 16'h1234, a + 16'h4321, a ^ 16'h0F0F,
                {a[7:0], a[15:8]}, a - 16'h1111, a ^ 16'h00AA};
    endfunction

    function automatic logic [LW-1:0] ref_get(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : hsh(a);
    endfunction

    function automatic logic [LW-1:0] pm_get(input logic [15:0] a);
        return pm_mem.exists(a) ? pm_mem[a] : hsh(a);
    endfunction

    task automatic i_issue(input logic [15:0] a);
        i_address = a;
        i_read    = 1'b1;
        iq.push_back(hsh(a & 16'hFFF0));
    endtask

    task automatic d_issue(input bit w, input logic [15:0] a, input logic [LW-1:0] wd);
        logic [15:0] al;
        al        = a & 16'hFFF0;
        d_address = a;
        d_wdata   = wd;
        if (w) begin
            d_write = 1'b1;
            d_read  = 1'($urandom_range(0, 1));
            ref_mem[al] = wd;
            dq.push_back({1'b1, {LW{1'b0}}});
        end else begin
            d_write = 1'b0;
            d_read  = 1'b1;
            dq.push_back({1'b0, ref_get(al)});
        end
    endtask

    task automatic d_issue_rand();
        logic [15:0] a;
        a = 16'h4000 | (16'($urandom_range(0, 7)) << 4) | 16'($urandom_range(0, 15));
        d_issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic wait_resp(input bit side_i);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (side_i ? i_resp : d_resp) begin
                got = 1'b1;
                break;
            end
        end
        check(side_i ? "i_timeout" : "d_timeout", LW'(got), LW'(1));
        tick();
    endtask

    // Physical memory model: random latency, stores writes, returns lines.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_pmem && (pmem_read || pmem_write)) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #2;
                end
                if (pmem_write) pm_mem[pmem_address] = pmem_wdata;
                else            a_rdata = pm_get(pmem_address);
                a_resp = 1'b1;
                @(posedge clk);
                #2;
                a_resp  = 1'b0;
                a_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: predicts grant owner from the arbitration rules, scores responses.
    initial begin
        int   sm;
        bit   own_i, pb, pi, pd;
        logic [LW:0] e;
        sm = 0; own_i = 1'b0; pb = 1'b0; pi = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sm = 0; pb = 1'b0; pi = 1'b0; pd = 1'b0;
            end else begin
                if (!pb && busy) begin
                    if (pd && pi && sm >= LIM) begin
                        own_i = 1'b1; sm = 0;
                    end else if (pd) begin
                        own_i = 1'b0; sm = pi ? ((sm == 15) ? 15 : sm + 1) : 0;
                    end else begin
                        own_i = 1'b1; sm = 0;
                    end
                end
                if (mon_en && (i_resp || d_resp)) begin
                    check("resp_both", LW'(i_resp & d_resp), LW'(0));
                    check("resp_owner", LW'(i_resp), LW'(own_i));
                    if (i_resp) begin
                        check("iq_nonempty", LW'(iq.size() > 0), LW'(1));
                        if (iq.size() > 0) check("i_rdata", i_rdata, iq.pop_front());
                    end else begin
                        check("dq_nonempty", LW'(dq.size() > 0), LW'(1));
                        if (dq.size() > 0) begin
                            e = dq.pop_front();
                            if (!e[LW]) check("d_rdata", d_rdata, e[LW-1:0]);
                        end
                    end
                end
                pb = busy; pi = i_read; pd = d_read | d_write;
            end
        end
    end

    initial begin
        int cnt;
        bit done;

        // Reset: outputs low even with a request pending.
        i_read = 1'b1;
        d_write = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pmem_read", LW'(pmem_read), LW'(0));
        check("rst_pmem_write", LW'(pmem_write), LW'(0));
        check("rst_resp", LW'({i_resp, d_resp}), LW'(0));
        check("rst_busy", LW'(busy), LW'(0));
        check("rst_addr", LW'(pmem_address), LW'(0));
        check("rst_wdata", pmem_wdata, '0);
        tick();
        rst = 1'b0; i_read = 1'b0; d_write = 1'b0;
        tick();

        // I-only read.
        i_read = 1'b1; i_address = 16'h1236;
        tick();
        check("i_pmem_read", LW'(pmem_read), LW'(1));
        check("i_pmem_write", LW'(pmem_write), LW'(0));
        check("i_pmem_addr", LW'(pmem_address), LW'(16'h1230));
        check("i_pmem_wdata", pmem_wdata, '0);
        check("i_busy", LW'(busy), LW'(1));
        tick(); tick();
        m_resp = 1'b1; m_rdata = {16{8'hA5}};
        #1;
        check("i_resp_hi", LW'(i_resp), LW'(1));
        check("i_rdata_dir", i_rdata, {16{8'hA5}});
        check("i_d_resp_lo", LW'(d_resp), LW'(0));
        tick();
        m_resp = 1'b0; i_read = 1'b0;
        #1;
        check("i_resp_pulse", LW'(i_resp), LW'(0));
        check("i_idle", LW'(busy), LW'(0));

        // Stray pmem_resp in IDLE.
        tick();
        m_resp = 1'b1;
        #1;
        check("idle_resp_ignored", LW'({i_resp, d_resp}), LW'(0));
        tick();
        m_resp = 1'b0;
        #1;
        check("idle_stays", LW'(busy), LW'(0));

        // D write.
        d_write = 1'b1; d_address = 16'h4008;
        d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        tick();
        check("dw_pmem_write", LW'(pmem_write), LW'(1));
        check("dw_pmem_read", LW'(pmem_read), LW'(0));
        check("dw_pmem_addr", LW'(pmem_address), LW'(16'h4000));
        check("dw_pmem_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        tick();
        m_resp = 1'b1;
        #1;
        check("dw_d_resp", LW'(d_resp), LW'(1));
        check("dw_i_resp", LW'(i_resp), LW'(0));
        tick();
        m_resp = 1'b0; d_write = 1'b0;

        // Read and write both asserted: write wins.
        tick();
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h4013;
        tick();
        check("rw_pmem_write", LW'(pmem_write), LW'(1));
        check("rw_pmem_read", LW'(pmem_read), LW'(0));
        check("rw_addr", LW'(pmem_address), LW'(16'h4010));
        m_resp = 1'b1;
        #1;
        check("rw_d_resp", LW'(d_resp), LW'(1));
        tick();
        m_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
        #1;
        check("rw_single_resp", LW'(d_resp), LW'(0));
        tick();
        check("rw_idle", LW'({busy, d_resp}), LW'(0));

        // Reset while serving a D write, then a stale pmem_resp.
        d_write = 1'b1; d_address = 16'h4020;
        tick();
        check("rs_pmem_write", LW'(pmem_write), LW'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rs_write_cleared", LW'(pmem_write), LW'(0));
        check("rs_busy_cleared", LW'(busy), LW'(0));
        d_write = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        m_resp = 1'b1;
        #1;
        check("rs_stale_resp", LW'({i_resp, d_resp}), LW'(0));
        tick();
        m_resp = 1'b0;
        #1;
        check("rs_idle", LW'(busy), LW'(0));

        // Scoreboarded phases with the memory model.
        auto_pmem = 1'b1;
        mon_en    = 1'b1;
        tick();

        // Simultaneous requests: D first, then I.
        i_issue(16'h0456);
        d_issue(1'b0, 16'h4045, '0);
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                done = 1'b1;
                check("simul_d_first", LW'(d_resp), LW'(1));
            end
        end
        check("simul_timeout", LW'(done), LW'(1));
        tick();
        d_read = 1'b0;
        wait_resp(1'b1);
        i_read = 1'b0;
        tick();

        // Starvation: D back-to-back while I waits.
        i_issue(16'h2222);
        d_issue_rand();
        cnt = 0; done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (i_resp) begin
                done = 1'b1;
            end else if (d_resp) begin
                cnt++;
                tick();
                d_issue_rand();
            end
        end
        check("starve_timeout", LW'(done), LW'(1));
        check("starve_d_grants", LW'(cnt), LW'(LIM));
        tick();
        i_read = 1'b0;
        wait_resp(1'b0);
        d_read = 1'b0; d_write = 1'b0;
        tick();

        // Random concurrent traffic.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(1, 3)) tick();
                    i_issue({2'b00, 14'($urandom)});
                    wait_resp(1'b1);
                    i_read = 1'b0;
                end
            end
            begin
                d_issue_rand();
                for (int n = 0; n < 40; n++) begin
                    wait_resp(1'b0);
                    if (n == 39) begin
                        d_read = 1'b0; d_write = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        d_issue_rand();
                    end else begin
                        d_read = 1'b0; d_write = 1'b0;
                        repeat ($urandom_range(1, 2)) tick();
                        d_issue_rand();
                    end
                end
            end
        join

        repeat (8) tick();
        check("iq_drained", LW'(iq.size()), LW'(0));
        check("dq_drained", LW'(dq.size()), LW'(0));
        check("final_idle", LW'(busy), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
